// File: rtl/conv_sequencer.sv
// conv_sequencer: loop-nest controller for the GEMM convolution datapath.
// Walks output pixels x kernel taps, drives SRAM reads and latency-aligned MAC strobes.
module conv_sequencer #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] img_row,
  input  logic [ADDR_WIDTH-1:0] img_col,
  input  logic [ADDR_WIDTH-1:0] ker_row,
  input  logic [ADDR_WIDTH-1:0] ker_col,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] ker_addr,
  output logic                  mac_valid,
  output logic                  mac_first,
  output logic                  mac_last,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned SW    = AW + 3;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  // Latched geometry, kept as loop limits (count - 1) plus the image stride.
  logic [AW-1:0] img_col_q, img_col_d;
  logic [AW-1:0] kc_max_q, kc_max_d;
  logic [AW-1:0] kr_max_q, kr_max_d;
  logic [AW-1:0] oc_max_q, oc_max_d;
  logic [AW-1:0] or_max_q, or_max_d;

  // Loop counters describe the tap most recently issued to the SRAMs.
  logic [AW-1:0] kc_q, kc_d;
  logic [AW-1:0] kr_q, kr_d;
  logic [AW-1:0] oc_q, oc_d;
  logic [AW-1:0] or_q, or_d;

  // Incremental address bases: or*img_col, or*img_col+oc, (or+kr)*img_col+oc.
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] pix_base_q, pix_base_d;
  logic [AW-1:0] tap_row_q, tap_row_d;
  logic [AW-1:0] img_addr_q, img_addr_d;
  logic [AW-1:0] ker_addr_q, ker_addr_d;
  logic [AW-1:0] out_pix_q, out_pix_d;

  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] drain_q, drain_d;

  logic [SW-1:0] pipe_q [READ_LAT];

  logic          cfg_bad_c;
  logic          kc_wrap_c, kr_wrap_c, oc_wrap_c, or_wrap_c;
  logic          last_tap_c, first_c, last_c;
  logic [AW-1:0] pix_next_c, row_next_c, tap_next_c;
  logic [SW-1:0] strobe_in_c;

  assign cfg_bad_c = (ker_row == '0) || (ker_col == '0) ||
                     (ker_row > img_row) || (ker_col > img_col);

  assign kc_wrap_c  = (kc_q == kc_max_q);
  assign kr_wrap_c  = (kr_q == kr_max_q);
  assign oc_wrap_c  = (oc_q == oc_max_q);
  assign or_wrap_c  = (or_q == or_max_q);
  assign last_tap_c = kc_wrap_c && kr_wrap_c && oc_wrap_c && or_wrap_c;

  assign pix_next_c = pix_base_q + AW'(1);
  assign row_next_c = row_base_q + img_col_q;
  assign tap_next_c = tap_row_q + img_col_q;

  assign first_c = (kr_q == '0) && (kc_q == '0);
  assign last_c  = kr_wrap_c && kc_wrap_c;

  // Strobes travel with the read; gated so idle slots carry all-zero payload.
  assign strobe_in_c = {rd_en_q, rd_en_q & first_c, rd_en_q & last_c,
                        {AW{rd_en_q}} & out_pix_q};

  // Next-state, loop advance and registered-output decode.
  always_comb begin
    state_d    = state_q;
    img_col_d  = img_col_q;
    kc_max_d   = kc_max_q;
    kr_max_d   = kr_max_q;
    oc_max_d   = oc_max_q;
    or_max_d   = or_max_q;
    kc_d       = kc_q;
    kr_d       = kr_q;
    oc_d       = oc_q;
    or_d       = or_q;
    row_base_d = row_base_q;
    pix_base_d = pix_base_q;
    tap_row_d  = tap_row_q;
    img_addr_d = img_addr_q;
    ker_addr_d = ker_addr_q;
    out_pix_d  = out_pix_q;
    drain_d    = drain_q;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_RUN;
            img_col_d  = img_col;
            kc_max_d   = ker_col - AW'(1);
            kr_max_d   = ker_row - AW'(1);
            oc_max_d   = img_col - ker_col;
            or_max_d   = img_row - ker_row;
            kc_d       = '0;
            kr_d       = '0;
            oc_d       = '0;
            or_d       = '0;
            row_base_d = '0;
            pix_base_d = '0;
            tap_row_d  = '0;
            img_addr_d = '0;
            ker_addr_d = '0;
            out_pix_d  = '0;
            rd_en_d    = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (last_tap_c) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (!stall) begin
          rd_en_d = 1'b1;
          if (!kc_wrap_c) begin
            kc_d       = kc_q + AW'(1);
            img_addr_d = img_addr_q + AW'(1);
            ker_addr_d = ker_addr_q + AW'(1);
          end else if (!kr_wrap_c) begin
            kc_d       = '0;
            kr_d       = kr_q + AW'(1);
            tap_row_d  = tap_next_c;
            img_addr_d = tap_next_c;
            ker_addr_d = ker_addr_q + AW'(1);
          end else begin
            kc_d       = '0;
            kr_d       = '0;
            ker_addr_d = '0;
            out_pix_d  = out_pix_q + AW'(1);
            if (!oc_wrap_c) begin
              oc_d       = oc_q + AW'(1);
              pix_base_d = pix_next_c;
              tap_row_d  = pix_next_c;
              img_addr_d = pix_next_c;
            end else begin
              oc_d       = '0;
              or_d       = or_q + AW'(1);
              row_base_d = row_next_c;
              pix_base_d = row_next_c;
              tap_row_d  = row_next_c;
              img_addr_d = row_next_c;
            end
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == CNT_W'(READ_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      img_col_q  <= '0;
      kc_max_q   <= '0;
      kr_max_q   <= '0;
      oc_max_q   <= '0;
      or_max_q   <= '0;
      kc_q       <= '0;
      kr_q       <= '0;
      oc_q       <= '0;
      or_q       <= '0;
      row_base_q <= '0;
      pix_base_q <= '0;
      tap_row_q  <= '0;
      img_addr_q <= '0;
      ker_addr_q <= '0;
      out_pix_q  <= '0;
      drain_q    <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_col_q  <= img_col_d;
      kc_max_q   <= kc_max_d;
      kr_max_q   <= kr_max_d;
      oc_max_q   <= oc_max_d;
      or_max_q   <= or_max_d;
      kc_q       <= kc_d;
      kr_q       <= kr_d;
      oc_q       <= oc_d;
      or_q       <= or_d;
      row_base_q <= row_base_d;
      pix_base_q <= pix_base_d;
      tap_row_q  <= tap_row_d;
      img_addr_q <= img_addr_d;
      ker_addr_q <= ker_addr_d;
      out_pix_q  <= out_pix_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Strobe delay line matching the SRAM read latency; advances even during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= strobe_in_c;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign img_addr  = img_addr_q;
  assign ker_addr  = ker_addr_q;
  assign mac_valid = pipe_q[READ_LAT-1][SW-1];
  assign mac_first = pipe_q[READ_LAT-1][SW-2];
  assign mac_last  = pipe_q[READ_LAT-1][SW-3];
  assign out_addr  = pipe_q[READ_LAT-1][AW-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed checks of conv_sequencer at read latency 1 (dut1) and 2 (dut2).
module tb_conv_sequencer;

  localparam int unsigned AW = 13;
  localparam int NO_STALL = 100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic [AW-1:0] img_row, img_col, ker_row, ker_col;

  logic          rd_en1, mac_valid1, mac_first1, mac_last1, busy1, done1, err1;
  logic [AW-1:0] img_addr1, ker_addr1, out_addr1;
  logic          rd_en2, mac_valid2, mac_first2, mac_last2, busy2, done2, err2;
  logic [AW-1:0] img_addr2, ker_addr2, out_addr2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv_sequencer #(.ADDR_WIDTH(AW), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
    .stall(stall), .rd_en(rd_en1), .img_addr(img_addr1), .ker_addr(ker_addr1),
    .mac_valid(mac_valid1), .mac_first(mac_first1), .mac_last(mac_last1),
    .out_addr(out_addr1), .busy(busy1), .done(done1), .err(err1)
  );

  conv_sequencer #(.ADDR_WIDTH(AW), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
    .stall(stall), .rd_en(rd_en2), .img_addr(img_addr2), .ker_addr(ker_addr2),
    .mac_valid(mac_valid2), .mac_first(mac_first2), .mac_last(mac_last2),
    .out_addr(out_addr2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_geom(input int ir, input int ic, input int kr, input int kc);
    img_row = AW'(ir);
    img_col = AW'(ic);
    ker_row = AW'(kr);
    ker_col = AW'(kc);
  endtask

  // Tap index on the read port after edge t+j, or -1 when no read is issued.
  function automatic int tap_of(input int j, input int s, input int l, input int n);
    int t;
    if (j < 0) return -1;
    if (j < s) return (j < n) ? j : -1;
    if (j < s + l) return -1;
    t = j - l;
    return (t < n) ? t : -1;
  endfunction

  // Pulses start, then checks every cycle until the sequencer is idle again.
  task automatic run_seq(input string tag, input int rl, input int n, input int k,
                         input int s, input int l, input int restart_at,
                         input int exp_img[$], input int exp_ker[$]);
    int t, tm;
    logic o_rd, o_v, o_f, o_l, o_busy, o_done, o_err;
    logic [AW-1:0] o_img, o_ker, o_out;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= n + l + rl + 1; j++) begin
      if (rl == 1) begin
        o_rd = rd_en1; o_v = mac_valid1; o_f = mac_first1; o_l = mac_last1;
        o_busy = busy1; o_done = done1; o_err = err1;
        o_img = img_addr1; o_ker = ker_addr1; o_out = out_addr1;
      end else begin
        o_rd = rd_en2; o_v = mac_valid2; o_f = mac_first2; o_l = mac_last2;
        o_busy = busy2; o_done = done2; o_err = err2;
        o_img = img_addr2; o_ker = ker_addr2; o_out = out_addr2;
      end
      t  = tap_of(j, s, l, n);
      tm = tap_of(j - rl, s, l, n);
      chk($sformatf("%s.rd_en[%0d]", tag, j), 32'(o_rd), 32'(t >= 0));
      if (t >= 0) begin
        chk($sformatf("%s.img_addr[%0d]", tag, j), 32'(o_img), exp_img[t]);
        chk($sformatf("%s.ker_addr[%0d]", tag, j), 32'(o_ker), exp_ker[t]);
      end else if (j >= s && j < s + l) begin
        chk($sformatf("%s.img_frozen[%0d]", tag, j), 32'(o_img), exp_img[s-1]);
        chk($sformatf("%s.ker_frozen[%0d]", tag, j), 32'(o_ker), exp_ker[s-1]);
      end
      chk($sformatf("%s.mac_valid[%0d]", tag, j), 32'(o_v), 32'(tm >= 0));
      chk($sformatf("%s.mac_first[%0d]", tag, j), 32'(o_f), 32'(tm >= 0 && tm % k == 0));
      chk($sformatf("%s.mac_last[%0d]", tag, j), 32'(o_l), 32'(tm >= 0 && tm % k == k - 1));
      if (tm >= 0 && tm % k == k - 1) begin
        chk($sformatf("%s.out_addr[%0d]", tag, j), 32'(o_out), tm / k);
      end
      chk($sformatf("%s.busy[%0d]", tag, j), 32'(o_busy), 32'(j <= n + l + rl));
      chk($sformatf("%s.done[%0d]", tag, j), 32'(o_done), 32'(j == n + l + rl));
      chk($sformatf("%s.err[%0d]", tag, j), 32'(o_err), 0);
      stall = (j + 1 >= s) && (j + 1 < s + l);
      start = (j + 1 == restart_at);
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int img3[$];
    int ker3[$];
    int img20[$];
    int ker20[$];
    img3 = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
    ker3 = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 20; i++) begin
      img20.push_back(i);
      ker20.push_back(0);
    end

    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    set_geom(0, 0, 0, 0);
    tick();
    tick();
    chk("reset.rd_en", 32'(rd_en1), 0);
    chk("reset.busy", 32'(busy1), 0);
    chk("reset.done", 32'(done1), 0);
    chk("reset.err", 32'(err1), 0);
    chk("reset.mac_valid", 32'(mac_valid2), 0);
    chk("reset.img_addr", 32'(img_addr1), 0);
    rst = 1'b0;
    tick();

    // 3x3 image, 2x2 kernel, latency 1
    set_geom(3, 3, 2, 2);
    run_seq("base", 1, 16, 4, NO_STALL, 0, -1, img3, ker3);
    repeat (3) tick();

    // 4x5 image, 1x1 kernel, latency 2
    set_geom(4, 5, 1, 1);
    run_seq("k1x1", 2, 20, 1, NO_STALL, 0, -1, img20, ker20);
    repeat (3) tick();

    // stall for 3 cycles after the 5th tap
    set_geom(3, 3, 2, 2);
    run_seq("stall", 1, 16, 4, 5, 3, -1, img3, ker3);
    repeat (3) tick();

    // kernel taller than image is rejected
    set_geom(3, 3, 4, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg.err", 32'(err1), 1);
    chk("cfg.err_lat2", 32'(err2), 1);
    chk("cfg.busy", 32'(busy1), 0);
    chk("cfg.rd_en", 32'(rd_en1), 0);
    chk("cfg.done", 32'(done1), 0);
    tick();
    chk("cfg.err_clear", 32'(err1), 0);
    chk("cfg.busy_after", 32'(busy1), 0);
    chk("cfg.rd_en_after", 32'(rd_en1), 0);
    chk("cfg.done_after", 32'(done1), 0);
    set_geom(3, 3, 2, 2);
    run_seq("after_err", 1, 16, 4, NO_STALL, 0, -1, img3, ker3);
    repeat (3) tick();

    // reset in the middle of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.rd_en", 32'(rd_en1), 0);
    chk("abort.img_addr", 32'(img_addr1), 0);
    chk("abort.ker_addr", 32'(ker_addr1), 0);
    chk("abort.mac_valid", 32'(mac_valid1), 0);
    chk("abort.mac_first", 32'(mac_first1), 0);
    chk("abort.mac_last", 32'(mac_last1), 0);
    chk("abort.out_addr", 32'(out_addr1), 0);
    chk("abort.busy", 32'(busy1), 0);
    chk("abort.done", 32'(done1), 0);
    chk("abort.err", 32'(err1), 0);
    chk("abort.mac_valid_lat2", 32'(mac_valid2), 0);
    for (int i = 0; i < 25; i++) begin
      tick();
      chk($sformatf("abort.no_done[%0d]", i), 32'(done1), 0);
      chk($sformatf("abort.idle_rd[%0d]", i), 32'(rd_en1), 0);
    end
    run_seq("replay", 1, 16, 4, NO_STALL, 0, -1, img3, ker3);
    repeat (3) tick();

    // second start while running is ignored
    run_seq("restart", 1, 16, 4, NO_STALL, 0, 7, img3, ker3);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
